// File: rtl/debounce_sync_pkg.sv
// Shared types and defaults for the debounce/synchronizer input stage.
// Build option: DEBOUNCE_SYNC_GLITCH_CNT_EN adds the glitch counter.
package debounce_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_STABLE_CYCLES = 4;
  localparam int GLITCH_W          = 8;

endpackage

// File: rtl/debounce_sync_if.sv
// Level in, conditioned level and edge pulses out.
// Build option: DEBOUNCE_SYNC_GLITCH_CNT_EN adds glitch_cnt.
interface debounce_sync_if;
  import debounce_pkg::*;

  logic din;
  logic q_clean;
  logic rise;
  logic fall;
  logic busy;
`ifdef DEBOUNCE_SYNC_GLITCH_CNT_EN
  logic [GLITCH_W-1:0] glitch_cnt;

  modport master (
    output din,
    input  q_clean, rise, fall, busy,
    input  glitch_cnt
  );

  modport slave (
    input  din,
    output q_clean, rise, fall, busy,
    output glitch_cnt
  );
`else
  modport master (
    output din,
    input  q_clean, rise, fall, busy
  );

  modport slave (
    input  din,
    output q_clean, rise, fall, busy
  );
`endif

endinterface

// File: rtl/debounce_sync_sync_chain.sv
// N-flop level synchronizer with a loadable reset value.
// Plain flop-to-flop chain, nothing between stages.
module sync_chain #(
  parameter int   N       = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [N-1:0] ff;

  always_ff @(posedge clk) begin
    if (reset) ff <= {N{RST_VAL}};
    else       ff <= {ff[N-2:0], d};
  end

  assign q = ff[N-1];

endmodule

// File: rtl/debounce_sync.sv
// Synchronize and debounce a raw level; emit clean level and edge pulses.
// Build option: DEBOUNCE_SYNC_GLITCH_CNT_EN counts aborted changes.
module debounce_sync
  import debounce_pkg::*;
#(
  parameter int   SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int   STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter logic RESET_LEVEL   = 1'b0,
  parameter int   CNT_W         = 16
) (
  input  logic            clk,
  input  logic            reset,
  debounce_sync_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(STABLE_CYCLES - 1);

  logic             s;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             q_q, q_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  sync_chain #(
    .N       (SYNC_STAGES),
    .RST_VAL (RESET_LEVEL)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.din),
    .q     (s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      q_q     <= RESET_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Agreement drops any partial count; the old level wins.
  always_comb begin
    state_d = IDLE;
    cnt_d   = '0;
    q_d     = q_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (s != q_q) begin
      if (cnt_q == LAST) begin
        q_d    = s;
        rise_d = s;
        fall_d = ~s;
      end else begin
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = PENDING;
      end
    end
  end

  assign bus.q_clean = q_q;
  assign bus.rise    = rise_q;
  assign bus.fall    = fall_q;
  assign bus.busy    = (state_q == PENDING);

`ifdef DEBOUNCE_SYNC_GLITCH_CNT_EN
  logic [GLITCH_W-1:0] glitch_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      glitch_q <= '0;
    end else if (state_q == PENDING && s == q_q
                 && glitch_q != '1) begin
      glitch_q <= glitch_q + GLITCH_W'(1);
    end
  end

  assign bus.glitch_cnt = glitch_q;
`endif

endmodule
